// File: rtl/bitrev_reorder_buf.sv
// -----------------------------------------------------------------------------
// bitrev_reorder_buf
//
// Purpose:
//   Ping-pong frame reorder buffer. Samples arrive in natural index order and
//   each completed frame leaves in bit-reversed index order. There are two
//   banks of N = 2**LOG2N samples. One bank fills while the other drains.
//   Both sides use a valid/ready handshake.
//
// Parameters:
//   DATA_W  sample width in bits
//   LOG2N   log2 of the frame length (legal range 1..10)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data is valid this cycle
//   in_ready   buffer can accept a sample this cycle
//   in_data    input sample, natural order
//   in_last    producer's end-of-frame marker (checked only)
//   out_valid  out_data is valid this cycle
//   out_ready  consumer accepts out_data this cycle
//   out_data   output sample, bit-reversed order (0 when not valid)
//   out_last   final sample of the output frame
//   frame_err  sticky framing error (in_last disagreed with the write index)
// -----------------------------------------------------------------------------
module bitrev_reorder_buf #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_err
);

    localparam int              N       = 1 << LOG2N;
    localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] IDX_ONE = LOG2N'(1);

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    logic             wr_bank_q,   wr_bank_d;
    logic [LOG2N-1:0] wr_idx_q,    wr_idx_d;
    logic             rd_bank_q,   rd_bank_d;
    logic [LOG2N-1:0] rd_idx_q,    rd_idx_d;
    logic [1:0]       full_q,      full_d;
    logic             frame_err_q, frame_err_d;

    logic             accept;
    logic             xfer;
    logic             wr_at_end;
    logic             rd_at_end;
    logic [LOG2N-1:0] rd_addr_rev;
    logic [DATA_W-1:0] rd_word [2];

    // in_ready and out_valid are functions of registered state only. This
    // keeps in_ready independent of out_ready, so a freed bank becomes
    // visible to the producer one cycle after its last transfer.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];

    assign accept    = in_valid  && in_ready;
    assign xfer      = out_valid && out_ready;
    assign wr_at_end = (wr_idx_q == IDX_MAX);
    assign rd_at_end = (rd_idx_q == IDX_MAX);

    // -------------------------------------------------------------------------
    // Bit-reversed read address: bit i of the address is bit LOG2N-1-i of
    // the read index.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : gen_bitrev
            assign rd_addr_rev[gi] = rd_idx_q[LOG2N-1-gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sample storage: two banks of N words. The banks are not reset, and
    // stale contents are never visible because out_data is masked unless the
    // bank being read is full. The read is combinational so that a sample
    // is presented in the cycle its bank becomes full.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_bank
            logic [DATA_W-1:0] mem_q [N];
            logic              bank_we;

            assign bank_we = rst_n && accept && (wr_bank_q == 1'(gi));

            always_ff @(posedge clk) begin
                if (bank_we) begin
                    mem_q[wr_idx_q] <= in_data;
                end
            end

            assign rd_word[gi] = mem_q[rd_addr_rev];
        end
    endgenerate

    assign out_data  = out_valid ? rd_word[rd_bank_q] : '0;
    assign out_last  = out_valid && rd_at_end;
    assign frame_err = frame_err_q;

    // -------------------------------------------------------------------------
    // Next-state logic. A fill and a drain in the same cycle always touch
    // different full bits: writes only target a non-full bank, and reads
    // only come from a full bank. Both updates can therefore be applied
    // unconditionally.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        full_d      = full_q;
        frame_err_d = frame_err_q;

        if (accept) begin
            // Index wraps modulo N through the natural overflow of the add.
            wr_idx_d = wr_idx_q + IDX_ONE;
            if (wr_at_end) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
            // in_last only flags a mismatch. Frame boundaries always come
            // from the write index.
            if (in_last != wr_at_end) begin
                frame_err_d = 1'b1;
            end
        end

        if (xfer) begin
            rd_idx_d = rd_idx_q + IDX_ONE;
            if (rd_at_end) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            full_q      <= 2'b00;
            frame_err_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// -----------------------------------------------------------------------------
// tb_bitrev_reorder_buf
//
// Directed testbench for bitrev_reorder_buf with DATA_W=16 and LOG2N=4.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_bitrev_reorder_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        frame_err;

    int n_asserts;
    int n_fail;

    // Hand-computed 4-bit reversal of 0..15.
    int exp_br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    bitrev_reorder_buf #(
        .DATA_W (16),
        .LOG2N  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Writes one frame base+0..base+15 into an empty buffer. in_last is
    // asserted at index last_pos.
    task automatic write_frame(input int base, input int last_pos);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(base + i);
            in_last  = (i == last_pos);
            check($sformatf("wr_in_ready[%0d]", i), 32'(in_ready), 32'd1);
            check($sformatf("wr_out_valid[%0d]", i), 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drains one frame with out_ready held high. Expects base + bitrev(i).
    task automatic read_frame(input int base);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rd_valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("rd_data[%0d]", i), 32'(out_data), 32'(base + exp_br[i]));
            check($sformatf("rd_last[%0d]", i), 32'(out_last), 32'(i == 15));
            tick();
        end
        check("rd_done_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int acc;
        int j;
        int cyc;
        int jo;

        n_asserts = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        $display("reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

        // ---- 1: single frame ----
        write_frame(0, 15);
        check("s1_first_valid", 32'(out_valid), 32'd1);
        read_frame(0);
        check("s1_frame_err", 32'(frame_err), 32'd0);
        $display("scenario 1: single frame done");

        // ---- 2: streaming 4 frames, out_ready=1 ----
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c < 64) begin
                in_valid = 1'b1;
                in_data  = 16'(c);
                in_last  = ((c % 16) == 15);
                check($sformatf("s2_in_ready[%0d]", c), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (c < 16) begin
                check($sformatf("s2_out_valid[%0d]", c), 32'(out_valid), 32'd0);
            end else begin
                jo = c - 16;
                check($sformatf("s2_out_valid[%0d]", c), 32'(out_valid), 32'd1);
                check($sformatf("s2_out_data[%0d]", c), 32'(out_data),
                      32'(16 * (jo / 16) + exp_br[jo % 16]));
                check($sformatf("s2_out_last[%0d]", c), 32'(out_last), 32'((jo % 16) == 15));
            end
            tick();
        end
        check("s2_end_valid", 32'(out_valid), 32'd0);
        check("s2_frame_err", 32'(frame_err), 32'd0);
        $display("scenario 2: streaming done");

        // ---- 3: backpressure ----
        out_ready = 1'b0;
        acc = 0;
        for (int a = 0; a < 40; a++) begin
            in_valid = 1'b1;
            in_data  = 16'(acc);
            in_last  = ((acc % 16) == 15);
            check($sformatf("s3_in_ready[%0d]", a), 32'(in_ready), 32'(a < 32));
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("s3_accepted", 32'(acc), 32'd32);
        check("s3_full_in_ready",  32'(in_ready),  32'd0);
        check("s3_full_out_valid", 32'(out_valid), 32'd1);
        check("s3_full_out_data",  32'(out_data),  32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("s3_drain_in_ready[%0d]", i), 32'(in_ready), 32'd0);
            check($sformatf("s3_drain_data[%0d]", i), 32'(out_data), 32'(exp_br[i]));
            tick();
        end
        check("s3_freed_in_ready", 32'(in_ready), 32'd1);
        read_frame(16);
        $display("scenario 3: backpressure done");

        // ---- 4: random stalls ----
        out_ready = 1'b0;
        write_frame(16'hA0, 15);
        j   = 0;
        cyc = 0;
        while (j < 16 && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            check($sformatf("s4_valid[%0d]", cyc), 32'(out_valid), 32'd1);
            check($sformatf("s4_data[%0d]", cyc), 32'(out_data), 32'(16'hA0 + exp_br[j]));
            check($sformatf("s4_last[%0d]", cyc), 32'(out_last), 32'(j == 15));
            if (out_ready) j++;
            cyc++;
            tick();
        end
        out_ready = 1'b0;
        check("s4_drained", 32'(j), 32'd16);
        check("s4_end_valid", 32'(out_valid), 32'd0);
        $display("scenario 4: stall stability done after %0d cycles", cyc);

        // ---- 5: framing error (in_last on index 7) ----
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h300 + i);
            in_last  = (i == 7);
            check($sformatf("s5_frame_err[%0d]", i), 32'(frame_err), 32'(i > 7));
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("s5_err_after", 32'(frame_err), 32'd1);
        read_frame(16'h300);
        check("s5_err_sticky", 32'(frame_err), 32'd1);
        $display("scenario 5: framing error done");

        // ---- 6: reset mid-operation ----
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h500 + i);
            in_last  = ((i % 16) == 15);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("s6_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s6_in_ready",  32'(in_ready),  32'd1);
        check("s6_out_valid", 32'(out_valid), 32'd0);
        check("s6_out_data",  32'(out_data),  32'd0);
        check("s6_out_last",  32'(out_last),  32'd0);
        check("s6_frame_err", 32'(frame_err), 32'd0);
        write_frame(0, 15);
        read_frame(0);
        check("s6_final_err", 32'(frame_err), 32'd0);
        $display("scenario 6: reset mid-operation done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
